// File: rtl/obj_fb_writer.sv
// OBJ framebuffer writer: packs 12-bit pixels into 64-bit DDR words (4 pixels/word)
// and zero-fills a whole framebuffer with paced 128-beat row bursts.
module obj_fb_writer #(
    parameter logic [31:0] FB_BASE = 32'h0
) (
    input  logic        clk,
    input  logic        RESET,
    input  logic        ce_13m,
    input  logic        pix_valid,
    output logic        pix_ready,
    input  logic        pix_buf,
    input  logic [8:0]  pix_x,
    input  logic [7:0]  pix_y,
    input  logic [11:0] pix_color,
    input  logic        flush,
    input  logic        clear_start,
    input  logic        clear_buf,
    output logic        busy,
    output logic        ddr_acquire,
    output logic        ddr_write,
    output logic        ddr_read,
    output logic [31:0] ddr_addr,
    output logic [63:0] ddr_wdata,
    output logic [7:0]  ddr_byteenable,
    output logic [7:0]  ddr_burstcnt,
    input  logic        ddr_busy
);

    typedef enum logic [2:0] {IDLE, HOLD, WR_ACQ, WR_BEAT, CLR_ACQ, CLR_BURST} state_e;

    state_e      state_q;
    logic [15:0] pend_key_q;
    logic [63:0] pend_data_q;
    logic [7:0]  pend_be_q;
    logic        clr_req_q, clr_buf_q;
    logic [7:0]  row_q;
    logic [6:0]  beat_q;
    logic [4:0]  gap_q;
    logic        acq_q, wr_q;
    logic [31:0] addr_q;
    logic [63:0] wdata_q;
    logic [7:0]  be_q, bc_q;

    logic [15:0] pix_key;
    logic        opaque, hit, take, have_word, clr_go;
    logic [63:0] merge_data;
    logic [7:0]  merge_be;

    assign pix_key   = {pix_buf, pix_y, pix_x[8:2]};
    assign opaque    = |pix_color[3:0];
    assign hit       = (pix_key == pend_key_q);
    assign take      = pix_valid & pix_ready & opaque;
    assign have_word = take | (state_q == HOLD);
    assign clr_go    = clear_start | clr_req_q;

    // A stalled pixel is taken on the cycle its predecessor's beat completes
    always_comb begin
        pix_ready = 1'b0;
        case (state_q)
            IDLE:    pix_ready = 1'b1;
            HOLD:    pix_ready = hit | ~opaque;
            WR_BEAT: pix_ready = ~ddr_busy & ~clr_req_q;
            default: pix_ready = 1'b0;
        endcase
    end

    always_comb begin
        merge_data = (state_q == HOLD) ? pend_data_q : 64'd0;
        merge_be   = (state_q == HOLD) ? pend_be_q : 8'd0;
        merge_data[{pix_x[1:0], 4'd0} +: 16] = {4'h0, pix_color};
        merge_be[{pix_x[1:0], 1'b0} +: 2]    = 2'b11;
    end

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            state_q     <= IDLE;
            pend_key_q  <= '0;
            pend_data_q <= '0;
            pend_be_q   <= '0;
            clr_req_q   <= 1'b0;
            clr_buf_q   <= 1'b0;
            row_q       <= '0;
            beat_q      <= '0;
            gap_q       <= '0;
            acq_q       <= 1'b0;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
            bc_q        <= '0;
        end else begin
            case (state_q)
                IDLE, HOLD: begin
                    if (take) begin
                        pend_key_q  <= pix_key;
                        pend_data_q <= merge_data;
                        pend_be_q   <= merge_be;
                    end
                    if (clear_start) clr_buf_q <= clear_buf;
                    if (clr_go && have_word) begin
                        clr_req_q <= 1'b1;
                        state_q   <= WR_ACQ;
                    end else if (clr_go) begin
                        clr_req_q <= 1'b0;
                        row_q     <= '0;
                        gap_q     <= 5'd16;
                        state_q   <= CLR_ACQ;
                    end else if (have_word && (flush || (pix_valid && !pix_ready))) begin
                        state_q <= WR_ACQ;
                    end else begin
                        state_q <= have_word ? HOLD : IDLE;
                    end
                end
                WR_ACQ: begin
                    acq_q <= 1'b1;
                    if (clear_start && !clr_req_q) begin
                        clr_req_q <= 1'b1;
                        clr_buf_q <= clear_buf;
                    end
                    if (acq_q && !ddr_busy) begin
                        wr_q    <= 1'b1;
                        addr_q  <= FB_BASE + {13'd0, pend_key_q, 3'b000};
                        wdata_q <= pend_data_q;
                        be_q    <= pend_be_q;
                        bc_q    <= 8'd1;
                        state_q <= WR_BEAT;
                    end
                end
                WR_BEAT: begin
                    if (clear_start && !clr_req_q) begin
                        clr_req_q <= 1'b1;
                        clr_buf_q <= clear_buf;
                    end
                    if (!ddr_busy) begin
                        wr_q        <= 1'b0;
                        acq_q       <= 1'b0;
                        pend_data_q <= '0;
                        pend_be_q   <= '0;
                        if (clr_req_q) begin
                            clr_req_q <= 1'b0;
                            row_q     <= '0;
                            gap_q     <= 5'd16;
                            state_q   <= CLR_ACQ;
                        end else if (take) begin
                            pend_key_q  <= pix_key;
                            pend_data_q <= merge_data;
                            pend_be_q   <= merge_be;
                            state_q     <= HOLD;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                // Acquire stays released for 16 ce_13m ticks between row bursts
                CLR_ACQ: begin
                    if (gap_q != 5'd16) begin
                        if (ce_13m) gap_q <= gap_q + 5'd1;
                    end else begin
                        acq_q <= 1'b1;
                        if (acq_q && !ddr_busy) begin
                            wr_q    <= 1'b1;
                            addr_q  <= FB_BASE + {13'd0, clr_buf_q, row_q, 10'd0};
                            wdata_q <= '0;
                            be_q    <= 8'hFF;
                            bc_q    <= 8'd128;
                            beat_q  <= '0;
                            state_q <= CLR_BURST;
                        end
                    end
                end
                CLR_BURST: begin
                    if (!ddr_busy) begin
                        beat_q <= beat_q + 7'd1;
                        if (beat_q == 7'd127) begin
                            wr_q    <= 1'b0;
                            acq_q   <= 1'b0;
                            row_q   <= row_q + 8'd1;
                            gap_q   <= '0;
                            state_q <= (row_q == 8'd255) ? IDLE : CLR_ACQ;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy           = (state_q != IDLE);
    assign ddr_acquire    = acq_q;
    assign ddr_write      = wr_q;
    assign ddr_read       = 1'b0;
    assign ddr_addr       = addr_q;
    assign ddr_wdata      = wdata_q;
    assign ddr_byteenable = be_q;
    assign ddr_burstcnt   = bc_q;

endmodule
